// File: rtl/bch_pkg.sv
// Shared BCH definitions: FSM states, LFSR step function, default codes.
package bch_pkg;

  typedef enum logic {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } bch_state_e;

  // Widest remainder the shared step function handles (P must stay below this).
  localparam int BCH_PMAX = 32;

  localparam int             BCH_63_51_N    = 63;
  localparam int             BCH_63_51_K    = 51;
  localparam logic [12:0]    BCH_63_51_POLY = 13'h1539;

  localparam int             BCH_63_45_N    = 63;
  localparam int             BCH_63_45_K    = 45;
  localparam logic [18:0]    BCH_63_45_POLY = 19'h782CF;

  // One division step: feed bit_in into a p-bit remainder with generator
  // low-order coefficients poly (x^p term implicit). Bits at and above p are
  // returned as zero so callers can truncate freely.
  function automatic logic [BCH_PMAX-1:0] bch_lfsr_step(
    input logic [BCH_PMAX-1:0] rem,
    input logic                bit_in,
    input logic [BCH_PMAX-1:0] poly,
    input int                  p
  );
    logic                fb;
    logic [BCH_PMAX-1:0] nxt;
    fb  = bit_in ^ rem[p-1];
    nxt = rem << 1;
    if (fb) nxt = nxt ^ poly;
    for (int i = 0; i < BCH_PMAX; i++) begin
      if (i >= p) nxt[i] = 1'b0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bch_stream_encoder_lfsr.sv
// Parity remainder register: divides the message by the generator while
// shifting in, then shifts the remainder out MSB first.
module bch_lfsr
  import bch_pkg::*;
#(
  parameter int         P        = 12,
  parameter logic [P:0] GEN_POLY = 13'h1539
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic shift_in,
  input  logic bit_in,
  input  logic shift_out,
  output logic msb
);

  localparam logic [P-1:0] POLY_LO = GEN_POLY[P-1:0];

  logic [P-1:0] rem;

  // Remainder update: clear wins, then division step, then plain shift-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
    end else if (clear) begin
      rem <= '0;
    end else if (shift_in) begin
      rem <= P'(bch_lfsr_step(BCH_PMAX'(rem), bit_in, BCH_PMAX'(POLY_LO), P));
    end else if (shift_out) begin
      rem <= {rem[P-2:0], 1'b0};
    end
  end

  assign msb = rem[P-1];

endmodule

// File: rtl/bch_stream_encoder.sv
// Systematic serial BCH encoder: echoes Kc message bits, then appends P parity
// bits. Single-bit output buffer with valid/ready on both sides.
//
// state  | meaning
// ST_MSG | accepting message bits, dividing into the remainder
// ST_PAR | input stalled, remainder shifted out as parity
module bch_stream_encoder
  import bch_pkg::*;
#(
  parameter int             N        = 63,
  parameter int             K        = 51,
  parameter logic [N-K:0]   GEN_POLY = 13'h1539,
  parameter int             SW       = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] cfg_shorten,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_data,
  output logic          m_last,
  output logic          busy
);

  localparam int P  = N - K;
  localparam int CW = $clog2(N + 1);

  bch_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] kc_q, kc_now;
  logic          m_valid_q, m_data_q, m_last_q, busy_q;
  logic          out_free, last_msg, last_par;
  logic          load_msg, load_par, s_ready_c;
  logic          lfsr_clear, lfsr_shift_in, lfsr_shift_out, lfsr_msb;

  assign out_free = !m_valid_q || m_ready;

  // Shortened message length for a codeword starting now; oversize shortening clamps to Kc = 1.
  always_comb begin
    kc_now = CW'(K);
    if (int'(cfg_shorten) >= K - 1) kc_now = CW'(1);
    else                             kc_now = CW'(K - int'(cfg_shorten));
  end

  // At the first bit the fresh length applies; afterwards the latched one.
  assign last_msg = (count_q == '0) ? (kc_now == CW'(1)) : ((count_q + CW'(1)) == kc_q);
  assign last_par = (count_q == CW'(P - 1));

  // Next-state, counter and datapath strobes.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    s_ready_c      = 1'b0;
    load_msg       = 1'b0;
    load_par       = 1'b0;
    lfsr_clear     = 1'b0;
    lfsr_shift_in  = 1'b0;
    lfsr_shift_out = 1'b0;
    case (state_q)
      ST_MSG: begin
        s_ready_c = out_free;
        if (s_valid && out_free) begin
          load_msg      = 1'b1;
          lfsr_shift_in = 1'b1;
          if (last_msg) begin
            state_d = ST_PAR;
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      ST_PAR: begin
        if (out_free) begin
          load_par = 1'b1;
          if (last_par) begin
            lfsr_clear = 1'b1;
            count_d    = '0;
            state_d    = ST_MSG;
          end else begin
            lfsr_shift_out = 1'b1;
            count_d        = count_q + CW'(1);
          end
        end
      end
      default: state_d = ST_MSG;
    endcase
  end

  // State register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MSG;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Latch the shortened length at the first accepted bit of each codeword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kc_q <= CW'(K);
    else if (load_msg && count_q == '0) kc_q <= kc_now;
  end

  // Single-bit output buffer: message echo or parity, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (load_msg) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s_data;
      m_last_q  <= 1'b0;
    end else if (load_par) begin
      m_valid_q <= 1'b1;
      m_data_q  <= lfsr_msb;
      m_last_q  <= last_par;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end
  end

  // Busy from the first accepted bit until the final parity bit leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  busy_q <= 1'b0;
    else if (load_msg)                           busy_q <= 1'b1;
    else if (m_valid_q && m_ready && m_last_q)   busy_q <= 1'b0;
  end

  bch_lfsr #(
    .P        (P),
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (lfsr_clear),
    .shift_in  (lfsr_shift_in),
    .bit_in    (s_data),
    .shift_out (lfsr_shift_out),
    .msb       (lfsr_msb)
  );

  assign s_ready = s_ready_c;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bch_stream_encoder.sv
// Directed bench for bch_stream_encoder with default BCH(63,51) parameters.
module tb_bch_stream_encoder;

  localparam int          N     = 63;
  localparam int          K     = 51;
  localparam int          P     = 12;
  localparam int          SW    = 6;
  localparam logic [12:0] GPOLY = 13'h1539;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] cfg_shorten = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_data = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_data;
  logic          m_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic       src_q[$];
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int         sready_low, stall_viol, b2b_viol, first_acc, last_out;
  bit         timed_out;

  always #5 clk = ~clk;

  bch_stream_encoder #(.N(N), .K(K), .GEN_POLY(GPOLY), .SW(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_shorten (cfg_shorten),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy)
  );

  // Golden parity by long division of msg(x)*x^P by g(x).
  function automatic logic [P-1:0] model_parity(input logic [63:0] msg, input int kc);
    logic [127:0] d;
    logic [127:0] g;
    d = 128'(msg) << P;
    g = 128'(GPOLY);
    for (int i = kc + P - 1; i >= P; i--) begin
      if (d[i]) d = d ^ (g << (i - P));
    end
    return d[P-1:0];
  endfunction

  task automatic clear_streams();
    src_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic add_cw(input logic [63:0] msg, input int kc);
    logic [P-1:0] par;
    par = model_parity(msg, kc);
    for (int i = kc - 1; i >= 0; i--) begin
      src_q.push_back(msg[i]);
      exp_q.push_back({1'b0, msg[i]});
    end
    for (int i = P - 1; i >= 0; i--) exp_q.push_back({1'(i == 0), par[i]});
  endtask

  // Drives src_q, collects transfers into obs_q; entered and left at posedge+1.
  task automatic run_stream(input bit rand_ready, input logic [SW-1:0] cfg_after, input int budget);
    int   si;
    int   cyc;
    logic prev_stall;
    logic prev_data;
    si = 0; cyc = 0; prev_stall = 1'b0; prev_data = 1'b0;
    sready_low = 0; stall_viol = 0; b2b_viol = 0; first_acc = -1; last_out = -1;
    obs_q.delete();
    while (obs_q.size() < exp_q.size() && cyc < budget) begin
      s_valid = (si < src_q.size());
      s_data  = s_valid ? src_q[si] : 1'b0;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (si > 0) cfg_shorten = cfg_after;
      @(negedge clk);
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
      if (!s_ready) sready_low++;
      if (m_valid && m_ready) begin
        obs_q.push_back({m_last, m_data});
        last_out = cyc;
        if (m_last && si < src_q.size() && !(s_valid && s_ready)) b2b_viol++;
      end
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        si++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid   = 1'b0;
    m_ready   = 1'b1;
    timed_out = (obs_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 1'b0) begin errors++; $display("FAIL reset_m_data got %b want 0", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_impulse();
    logic [50:0]  mo;
    logic [P-1:0] po;
    int           nlast;
    clear_streams();
    cfg_shorten = '0;
    add_cw(64'd1, K);
    run_stream(1'b0, '0, 500);
    checks++; if (timed_out || obs_q.size() != 63) begin errors++; $display("FAIL impulse_len got %0d want 63", obs_q.size()); end
    if (obs_q.size() == 63) begin
      nlast = 0;
      for (int i = 0; i < 51; i++) mo[50-i] = obs_q[i][0];
      for (int i = 0; i < P; i++) po[P-1-i] = obs_q[51+i][0];
      for (int i = 0; i < 63; i++) if (obs_q[i][1]) nlast++;
      checks++; if (mo !== 51'd1) begin errors++; $display("FAIL impulse_msg got %h want 1", mo); end
      checks++; if (po !== 12'h539) begin errors++; $display("FAIL impulse_parity got %h want 539", po); end
      checks++; if (nlast != 1 || obs_q[62][1] !== 1'b1) begin errors++; $display("FAIL impulse_last got count %0d last_bit %b want 1 at bit 63", nlast, obs_q[62][1]); end
    end
    checks++; if (sready_low != 12) begin errors++; $display("FAIL impulse_sready_low got %0d want 12", sready_low); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL impulse_busy_end got %b want 0", busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    int nones;
    clear_streams();
    cfg_shorten = '0;
    add_cw(64'd0, K);
    run_stream(1'b0, '0, 500);
    checks++; if (timed_out || obs_q.size() != 63) begin errors++; $display("FAIL zero_len got %0d want 63", obs_q.size()); end
    if (obs_q.size() == 63) begin
      nones = 0;
      for (int i = 0; i < 63; i++) if (obs_q[i][0]) nones++;
      checks++; if (nones != 0) begin errors++; $display("FAIL zero_data got %0d ones want 0", nones); end
      checks++; if (obs_q[62] !== 2'b10) begin errors++; $display("FAIL zero_last got %b want 10", obs_q[62]); end
    end
  endtask

  task automatic test_shorten();
    logic [P-1:0] po;
    int           nones;
    clear_streams();
    cfg_shorten = 6'd10;
    add_cw(64'd1, 41);
    run_stream(1'b0, 6'd0, 500);
    cfg_shorten = '0;
    checks++; if (timed_out || obs_q.size() != 53) begin errors++; $display("FAIL shorten_len got %0d want 53", obs_q.size()); end
    if (obs_q.size() == 53) begin
      nones = 0;
      for (int i = 0; i < 40; i++) if (obs_q[i][0]) nones++;
      for (int i = 0; i < P; i++) po[P-1-i] = obs_q[41+i][0];
      checks++; if (nones != 0 || obs_q[40][0] !== 1'b1) begin errors++; $display("FAIL shorten_msg got %0d leading ones, bit41 %b want 0 and 1", nones, obs_q[40][0]); end
      checks++; if (po !== 12'h539) begin errors++; $display("FAIL shorten_parity got %h want 539", po); end
      checks++; if (obs_q[52][1] !== 1'b1) begin errors++; $display("FAIL shorten_last got %b want 1", obs_q[52][1]); end
    end
  endtask

  task automatic test_clamp();
    logic [P-1:0] po;
    clear_streams();
    cfg_shorten = 6'd63;
    add_cw(64'd1, 1);
    run_stream(1'b0, 6'd63, 200);
    cfg_shorten = '0;
    checks++; if (timed_out || obs_q.size() != 13) begin errors++; $display("FAIL clamp_len got %0d want 13", obs_q.size()); end
    if (obs_q.size() == 13) begin
      for (int i = 0; i < P; i++) po[P-1-i] = obs_q[1+i][0];
      checks++; if (obs_q[0] !== 2'b01) begin errors++; $display("FAIL clamp_msg got %b want 01", obs_q[0]); end
      checks++; if (po !== 12'h539) begin errors++; $display("FAIL clamp_parity got %h want 539", po); end
      checks++; if (obs_q[12][1] !== 1'b1) begin errors++; $display("FAIL clamp_last got %b want 1", obs_q[12][1]); end
    end
    checks++; if (sready_low != 12) begin errors++; $display("FAIL clamp_sready_low got %0d want 12", sready_low); end
  endtask

  task automatic test_random();
    logic [63:0] msg;
    clear_streams();
    cfg_shorten = '0;
    for (int c = 0; c < 4; c++) begin
      msg = {32'($urandom), 32'($urandom)} & 64'h0007_FFFF_FFFF_FFFF;
      add_cw(msg, K);
    end
    run_stream(1'b1, '0, 3000);
    checks++; if (timed_out) begin errors++; $display("FAIL random_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_bit %0d got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL random_stall got %0d unstable cycles want 0", stall_viol); end
  endtask

  task automatic test_back_to_back();
    clear_streams();
    cfg_shorten = '0;
    add_cw(64'h0005_5555_AAAA_F00F, K);
    add_cw(64'd1, K);
    add_cw(64'h0007_0000_0000_8001, K);
    run_stream(1'b0, '0, 1000);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_bit %0d got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (b2b_viol != 0) begin errors++; $display("FAIL b2b_handover got %0d missed accepts want 0", b2b_viol); end
    checks++; if (last_out - first_acc != 189) begin errors++; $display("FAIL b2b_span got %0d cycles want 189", last_out - first_acc); end
    checks++; if (sready_low != 36) begin errors++; $display("FAIL b2b_sready_low got %0d want 36", sready_low); end
  endtask

  task automatic test_reset_mid();
    int           acc;
    int           cyc;
    logic [P-1:0] po;
    acc = 0; cyc = 0;
    cfg_shorten = '0;
    m_ready = 1'b1;
    while (acc < 20 && cyc < 100) begin
      s_valid = 1'b1;
      s_data  = acc[0] ^ acc[2];
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || m_valid !== 1'b1) begin errors++; $display("FAIL abort_busy got busy %b m_valid %b want 1 1", busy, m_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL abort_m_valid got %b last %b want 0 0", m_valid, m_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_clr got %b want 0", busy); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_streams();
    add_cw(64'd1, K);
    run_stream(1'b0, '0, 500);
    checks++; if (timed_out || obs_q.size() != 63) begin errors++; $display("FAIL abort_len got %0d want 63", obs_q.size()); end
    if (obs_q.size() == 63) begin
      for (int i = 0; i < P; i++) po[P-1-i] = obs_q[51+i][0];
      checks++; if (po !== 12'h539) begin errors++; $display("FAIL abort_parity got %h want 539", po); end
      checks++; if (obs_q[62] !== {1'b1, 1'b1}) begin errors++; $display("FAIL abort_last got %b want 11", obs_q[62]); end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_zero();
    test_shorten();
    test_clamp();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch_stream_encoder.md
# bch_stream_encoder

- Parametrised systematic binary BCH encoder: serial message bits in, the same bits out, then the N−K parity bits.
- Parity is computed by an LFSR on an arbitrary generator polynomial.
- Supports runtime shortening and full valid/ready backpressure on both sides; back-to-back codewords need no idle cycles.
- Sits in the TX chain between the bit source/scrambler and the modulator mapper.
- Replaces the fixed BCH(63,51) encoder.

## Interface
Parameters:
- N, 63: full codeword length.
- K, 51: full message length; P = N−K parity bits (localparam).
- GEN_POLY, 13'h1539: generator polynomial, width P+1, bit P = x^P term (must be 1), bit 0 must be 1.
- SW, 6: width of cfg_shorten.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_shorten  in  SW  leading message bits omitted (shortened code); sampled at the first accepted bit of each codeword.
- s_valid  in  1  input bit valid.
- s_ready  out  1  encoder accepts s_data this cycle.
- s_data  in  1  message bit, first bit = highest-degree coefficient.
- m_valid  out  1  output bit valid.
- m_ready  in  1  downstream accepts m_data.
- m_data  out  1  codeword bit.
- m_last  out  1  marks the final parity bit of a codeword.
- busy  out  1  high from first accepted bit until the last bit is accepted downstream.

## Operation
- Kc = K − S, where S = min(cfg_shorten, K−1); latched into an internal register at the first transfer of a codeword.
- Codeword on m_data: Kc message bits, then P parity bits, MSB (rem[P−1]) first. Total Kc+P bits.
- States:
  - MSG: s_ready = !m_valid || m_ready. On transfer:
    - fb = s_data ^ rem[P−1]; rem ← {rem[P−2:0],0} ^ (fb ? GEN_POLY[P−1:0] : 0).
    - Output register loads s_data; bit counter increments.
    - After the Kc-th transfer, go to PAR.
  - PAR: s_ready = 0. When the output register is free (!m_valid || m_ready):
    - Load rem[P−1] into the output register; rem ← rem << 1.
    - On the P-th parity load, set m_last, clear rem and counter, return to MSG.
- The next codeword's first bit may be accepted in the same cycle the last parity bit leaves the output register.
- cfg_shorten changes mid-codeword are ignored.
- Counter width $clog2(N+1).
- No state is exposed besides busy.

## Timing
- Reset (async assert, sync deassert by the top-level synchroniser): MSG state, rem=0, counter=0, m_valid=0, m_data=0, m_last=0, busy=0. s_ready=1 one cycle after deassert.
- Latency: bit accepted at edge t appears on m_data, m_valid=1 after edge t. One register stage; no combinational s_valid→m_valid path.
- s_ready depends combinationally on m_ready only (single-bit output buffer).
- Throughput: 1 bit/cycle when m_ready=1 throughout. A codeword of Kc bits occupies s_ready=0 for exactly P cycles.
- m_valid held with m_data/m_last stable while m_ready=0.
- Reset mid-codeword: partial codeword is discarded; no m_last is emitted for it.
- Shortening S ≥ K: clamped to S = K−1, giving Kc = 1.

## Structure
- Package bch_pkg holds:
  - state enum (MSG, PAR);
  - function bch_lfsr_step(rem, bit, poly), shared with the future decoder syndrome block;
  - default constants for BCH(63,51) and BCH(63,45).
- Natural sub-module: bch_lfsr, a parametrised remainder register with inputs shift_in/shift_out/clear.
- The top level holds the FSM, counter and output register.

## Test plan
- Default params, cfg_shorten=0, 50 zeros then a single 1, m_ready=1 → 51 message bits echoed, then parity 12'h539 MSB first; m_last on bit 63; s_ready low for exactly 12 cycles.
- All-zero 51-bit message → 63 zero output bits, m_last on bit 63.
- cfg_shorten=10, 40 zeros then a 1 → 53 output bits, parity 12'h539, m_last on bit 53.
- Random 51-bit messages with m_ready toggled pseudo-randomly (50%) → output stream bit-identical to a golden polynomial-division model; m_data stable while stalled.
- Three back-to-back codewords with s_valid=1 and m_ready=1 → no bubbles between codewords; first bit of codeword 2 accepted in the cycle codeword 1's m_last transfers.
- rst_n pulsed low after 20 bits of a codeword → m_valid=0 immediately. A following full codeword encodes correctly with parity unaffected by the aborted bits.
